// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with predict-not-taken redirect and timed IF/ID flush; FETCH_PC_CTRL_PERF_CNT_EN adds perf counters.
// Latency: redirect is combinational; redirected pc and flush appear 1 cycle after the mispredict.
// Backpressure: stall holds pc, but a redirect overrides stall and the flush window keeps counting.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        is_branch,
    input  logic [31:0] irreg_pc,
    output logic [31:0] pc,
    output logic        redirect,
    output logic        flush,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0]  state;
    logic [2:0]  flush_cnt;
    logic [31:0] ex_seq_pc;
    logic        br_resolved;
    logic        mp;

    assign ex_seq_pc = ex_pc + 32'd4;

    // Branches seen during the flush window are wrong-path and must not resolve.
    always_comb begin
        br_resolved = 1'b0;
        mp          = 1'b0;
        if (rstn && state == ST_RUN && ex_valid && is_branch) begin
            br_resolved = 1'b1;
            mp          = (irreg_pc != ex_seq_pc);
        end
    end

    assign redirect = mp;
    assign flush    = (state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc        <= RESET_PC;
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else begin
            if (mp) begin
                pc <= {irreg_pc[31:2], 2'b00};
            end else if (!stall) begin
                pc <= pc + 32'd4;
            end

            case (state)
                ST_RUN: begin
                    if (mp) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                default: begin
                    if (flush_cnt == 3'd0) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PC_CTRL_PERF_CNT_EN
    logic [31:0] branch_q;
    logic [31:0] mispredict_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            branch_q     <= 32'd0;
            mispredict_q <= 32'd0;
        end else begin
            if (br_resolved && branch_q != 32'hFFFF_FFFF) begin
                branch_q <= branch_q + 32'd1;
            end
            if (mp && mispredict_q != 32'hFFFF_FFFF) begin
                mispredict_q <= mispredict_q + 32'd1;
            end
        end
    end

    assign branch_cnt     = branch_q;
    assign mispredict_cnt = mispredict_q;
`else
    logic unused_br;
    assign unused_br      = br_resolved;
    assign branch_cnt     = 32'h0;
    assign mispredict_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: default instance plus a RESET_PC=0xFFFF_FFF8 instance for wrap.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rstn, stall, ex_valid, is_branch;
    logic [31:0] ex_pc, irreg_pc;
    logic [31:0] pc, branch_cnt, mispredict_cnt;
    logic        redirect, flush;

    logic        rstn2;
    logic [31:0] pc2, branch_cnt2, mispredict_cnt2;
    logic        redirect2, flush2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .is_branch(is_branch), .irreg_pc(irreg_pc), .pc(pc), .redirect(redirect),
        .flush(flush), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(2)) dut_wrap (
        .clk(clk), .rstn(rstn2), .stall(1'b0), .ex_valid(1'b0), .ex_pc(32'h0),
        .is_branch(1'b0), .irreg_pc(32'h0), .pc(pc2), .redirect(redirect2),
        .flush(flush2), .branch_cnt(branch_cnt2), .mispredict_cnt(mispredict_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mp);
`ifdef FETCH_PC_CTRL_PERF_CNT_EN
        chk({tag, "_br"}, branch_cnt, exp_br);
        chk({tag, "_mp"}, mispredict_cnt, exp_mp);
`else
        chk({tag, "_br"}, branch_cnt, 32'h0);
        chk({tag, "_mp"}, mispredict_cnt, 32'h0);
        if (exp_br == 32'hDEAD_BEEF || exp_mp == 32'hDEAD_BEEF) $display("note: unexpected perf arg");
`endif
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; rstn2 = 1'b0; stall = 1'b0;
        ex_valid = 1'b0; is_branch = 1'b0; ex_pc = 32'h0; irreg_pc = 32'h0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk_perf("rst", 32'h0, 32'h0);

        // Sequential fetch
        rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", pc, 32'(i * 4));
            chk("seq_flush", {31'h0, flush}, 32'h0);
            chk("seq_redirect", {31'h0, redirect}, 32'h0);
        end

        // Stall holds pc
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc, 32'h10);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", pc, 32'h14);

        // Mispredict: redirect to 0x40, flush for two cycles
        ex_valid = 1'b1; is_branch = 1'b1; ex_pc = 32'h8; irreg_pc = 32'h40;
        #1 chk("mp_redirect", {31'h0, redirect}, 32'h1);
        tick();
        chk("mp_pc", pc, 32'h40);
        chk("mp_flush0", {31'h0, flush}, 32'h1);
        chk("mp_ignored_in_flush", {31'h0, redirect}, 32'h0);
        chk_perf("mp1", 32'h1, 32'h1);
        tick();
        ex_valid = 1'b0;
        chk("mp_pc1", pc, 32'h44);
        chk("mp_flush1", {31'h0, flush}, 32'h1);
        tick();
        chk("mp_pc2", pc, 32'h48);
        chk("mp_flush_end", {31'h0, flush}, 32'h0);

        // Mispredict under stall with misaligned target; nested branch ignored
        stall = 1'b1; ex_valid = 1'b1; is_branch = 1'b1; ex_pc = 32'h8; irreg_pc = 32'h43;
        #1 chk("smp_redirect", {31'h0, redirect}, 32'h1);
        tick();
        chk("smp_pc", pc, 32'h40);
        chk("smp_flush", {31'h0, flush}, 32'h1);
        stall = 1'b0; ex_pc = 32'h40; irreg_pc = 32'h100;
        #1 chk("nested_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("nested_pc", pc, 32'h44);
        chk("nested_flush", {31'h0, flush}, 32'h1);
        ex_valid = 1'b0;
        tick();
        chk("smp_pc_end", pc, 32'h48);
        chk("smp_flush_end", {31'h0, flush}, 32'h0);
        chk_perf("smp", 32'h2, 32'h2);

        // Correctly predicted branch
        ex_valid = 1'b1; is_branch = 1'b1; ex_pc = 32'h20; irreg_pc = 32'h24;
        #1 chk("nt_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("nt_pc", pc, 32'h4C);
        chk("nt_flush", {31'h0, flush}, 32'h0);
        chk_perf("nt", 32'h3, 32'h2);

        // Non-branch / invalid instructions never redirect
        is_branch = 1'b0; irreg_pc = 32'h999;
        #1 chk("nobr_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("nobr_pc", pc, 32'h50);
        ex_valid = 1'b0; is_branch = 1'b1; irreg_pc = 32'h200;
        #1 chk("noval_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("noval_pc", pc, 32'h54);
        chk_perf("nobr", 32'h3, 32'h2);

        // Reset in the middle of a flush window
        ex_valid = 1'b1; is_branch = 1'b1; ex_pc = 32'h0; irreg_pc = 32'h80;
        #1 chk("rmp_redirect", {31'h0, redirect}, 32'h1);
        tick();
        chk("rmp_pc", pc, 32'h80);
        chk("rmp_flush", {31'h0, flush}, 32'h1);
        rstn = 1'b0;
        tick();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_flush", {31'h0, flush}, 32'h0);
        chk_perf("midrst", 32'h0, 32'h0);
        #1 chk("rst_gates_redirect", {31'h0, redirect}, 32'h0);
        tick();
        chk("rst_hold_pc", pc, 32'h0);
        ex_valid = 1'b0; rstn = 1'b1;
        tick();
        chk("post_rst_pc", pc, 32'h4);
        chk("post_rst_flush", {31'h0, flush}, 32'h0);

        // Wraparound from RESET_PC = 0xFFFF_FFF8
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
        rstn2 = 1'b1;
        tick();
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", pc2, 32'h0000_0000);
        tick();
        chk("wrap_pc3", pc2, 32'h0000_0004);
        chk("wrap_flush", {31'h0, flush2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-side PC controller, directly downstream of the EX-stage irregular-PC generator; consumes its target address (irreg_pc) and branch qualifier.
- Holds the architectural fetch PC and advances it by 4 under a static predict-not-taken policy.
- Detects mispredictions, redirects fetch, and kills wrong-path IF/ID instructions with a timed flush window.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
FLUSH_CYCLES, 2, cycles flush stays high after a redirect; legal range 1..7

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  synchronous active-low reset
stall  in  1  hold fetch PC this cycle (hazard / I-mem not ready)
ex_valid  in  1  EX-stage instruction is live
ex_pc  in  32  PC of EX-stage instruction
is_branch  in  1  EX instruction is branch/jump
irreg_pc  in  32  resolved next PC from EX (0 when not branch)
pc  out  32  current fetch PC
redirect  out  1  combinational pulse: misprediction detected this cycle
flush  out  1  registered kill for IF/ID contents
branch_cnt  out  32  resolved branches (PERF_CNT_EN)
mispredict_cnt  out  32  redirects taken (PERF_CNT_EN)

Behaviour:
- Reset (rstn=0 at edge): pc=RESET_PC, state=RUN, flush=0, flush counter=0, both perf counters=0. Takes effect regardless of state, including mid-FLUSH. redirect is 0 while rstn=0.
- Misprediction condition (mp): state==RUN && ex_valid && is_branch && (irreg_pc != ex_pc+4). All adds are 32-bit modulo.
- redirect = mp, combinational, same cycle.
- Next-PC priority, highest first:
  - mp: pc <= {irreg_pc[31:2],2'b00}. Low bits are forced to 0; no fault is raised.
  - stall: pc holds.
  - otherwise: pc <= pc+4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect overrides stall: a mispredict with stall=1 still loads the target.
- Two states:
  - RUN: on mp, next state is FLUSH and the counter is loaded with FLUSH_CYCLES-1; otherwise stay in RUN.
  - FLUSH: is_branch/ex_valid are ignored, so mp=0 and no nested redirect. Counter decrements every cycle, including stalled cycles. At counter==0, next state is RUN.
- flush = (state==FLUSH), registered. It rises on the edge after the mp cycle and stays high for exactly FLUSH_CYCLES cycles.
- In FLUSH the PC still advances by 4 per non-stalled cycle from the redirect target.
- A correctly predicted branch (irreg_pc == ex_pc+4) causes no redirect and no flush.
- ex_valid=0 or is_branch=0 never redirects, whatever irreg_pc holds.
- Latency: the redirected pc is visible 1 cycle after the mp cycle.

Optional Feature:
- Macro: FETCH_PC_CTRL_PERF_CNT_EN.
- Defined:
  - branch_cnt increments on each cycle with state==RUN && ex_valid && is_branch.
  - mispredict_cnt increments on each mp cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: no counter flops; both outputs tie to 32'h0. Port list is identical either way.

Test Plan:
- Reset, then rstn=1 with stall=0 for 4 cycles -> pc 0x0,0x4,0x8,0xC,0x10; flush=0, redirect=0 throughout.
- stall=1 for 3 cycles with pc=0x10 -> pc holds 0x10; stall release -> 0x14 next cycle.
- ex_valid=1, is_branch=1, ex_pc=0x8, irreg_pc=0x40 (FLUSH_CYCLES=2) -> redirect=1 that cycle; next pc=0x40, flush=1 for exactly 2 cycles; pc 0x44, 0x48 during the window; RUN afterwards.
- Same as previous but stall=1 in the mp cycle, then irreg_pc=0x43 -> pc=0x40 anyway; second branch issued during FLUSH with irreg_pc=0x100 -> ignored, pc continues +4.
- Not-taken branch: ex_pc=0x20, irreg_pc=0x24 -> no redirect, no flush; mispredict_cnt unchanged, branch_cnt +1 (PERF_CNT_EN).
- RESET_PC=32'hFFFF_FFF8, no stall -> pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; rstn=0 mid-FLUSH -> flush=0, pc=RESET_PC next cycle.
